// File: rtl/usbfs_tx_pkt_if.sv
// Endpoint-side fill/handshake signals and the serializer byte stream of the
// USB-FS IN packet stage.
interface usbfs_tx_pkt_if #(
  parameter int unsigned MAX_PKT = 8
);
  localparam int unsigned IDX_W = $clog2(MAX_PKT);

  logic             i_inTok;
  logic             i_etValid;
  logic             i_etStall;
  logic             o_etTxAccepted;
  logic             i_etWrEn;
  logic [IDX_W-1:0] i_etWrIdx;
  logic [7:0]       i_etWrByte;
  logic             o_etReady;
  logic             i_ackRcvd;
  logic             i_hsTimeout;
  logic             i_toggleClr;
  logic             o_txValid;
  logic             i_txReady;
  logic [7:0]       o_txData;
  logic             o_txLast;

  modport slave (
    input  i_inTok, i_etValid, i_etStall, i_etWrEn, i_etWrIdx, i_etWrByte,
    input  i_ackRcvd, i_hsTimeout, i_toggleClr, i_txReady,
    output o_etTxAccepted, o_etReady, o_txValid, o_txData, o_txLast
  );

  modport master (
    output i_inTok, i_etValid, i_etStall, i_etWrEn, i_etWrIdx, i_etWrByte,
    output i_ackRcvd, i_hsTimeout, i_toggleClr, i_txReady,
    input  o_etTxAccepted, o_etReady, o_txValid, o_txData, o_txLast
  );
endinterface

// File: rtl/usbfs_tx_pkt.sv
// USB-FS IN endpoint packet stage: buffers the endpoint payload on an IN token
// and streams PID / payload / CRC16 (or NAK / STALL) to the byte serializer.
module usbfs_tx_pkt #(
  parameter int unsigned MAX_PKT = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  usbfs_tx_pkt_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(MAX_PKT);
  localparam int unsigned CNT_W = $clog2(MAX_PKT + 1);

  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PID, S_DATA, S_CRCL, S_CRCH, S_WAITHS
  } state_e;

  state_e           state_q, state_d;
  logic             toggle_q, toggle_d;
  logic             pend_q, pend_d;
  logic             hs_q, hs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [15:0]      crc_q, crc_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic             acc_q, acc_d;
  logic             rdy_q, rdy_d;
  logic [7:0]       mem_q [MAX_PKT];
  logic             mem_we;
  logic             tx_fire;
  logic             tog_eff;
  logic             pend_eff;
  logic [7:0]       data_pid;

  // One reflected CRC16 (0xA001) step over a byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int b = 0; b < 8; b++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign tx_fire  = valid_q & bus.i_txReady;
  assign tog_eff  = toggle_q & ~bus.i_toggleClr;
  assign pend_eff = pend_q & ~bus.i_toggleClr;
  assign data_pid = tog_eff ? PID_DATA1 : PID_DATA0;

  always_comb begin
    state_d  = state_q;
    toggle_d = toggle_q;
    pend_d   = pend_q;
    hs_d     = hs_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    crc_d    = crc_q;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    acc_d    = 1'b0;
    rdy_d    = 1'b0;
    mem_we   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_inTok) begin
          if (bus.i_etStall || (!pend_eff && !bus.i_etValid)) begin
            state_d = S_PID;
            hs_d    = 1'b1;
            valid_d = 1'b1;
            data_d  = bus.i_etStall ? PID_STALL : PID_NAK;
            last_d  = 1'b1;
          end else if (pend_eff) begin
            state_d = S_PID;
            hs_d    = 1'b0;
            valid_d = 1'b1;
            data_d  = data_pid;
            last_d  = 1'b0;
            crc_d   = 16'hFFFF;
            idx_d   = '0;
          end else begin
            state_d = S_FILL;
            acc_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_FILL: begin
        if (bus.i_etWrEn) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
        // Leave on the first idle cycle or when the write fills the buffer.
        if (!bus.i_etWrEn || (cnt_q == CNT_W'(MAX_PKT - 1))) begin
          state_d = S_PID;
          pend_d  = 1'b1;
          hs_d    = 1'b0;
          valid_d = 1'b1;
          data_d  = data_pid;
          last_d  = 1'b0;
          crc_d   = 16'hFFFF;
          idx_d   = '0;
        end
      end
      S_PID: begin
        if (tx_fire) begin
          if (hs_q) begin
            state_d = S_IDLE;
            hs_d    = 1'b0;
            valid_d = 1'b0;
            data_d  = 8'h00;
            last_d  = 1'b0;
          end else if (cnt_q == '0) begin
            state_d = S_CRCL;
            data_d  = ~crc_q[7:0];
          end else begin
            state_d = S_DATA;
            data_d  = mem_q[0];
            idx_d   = CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (tx_fire) begin
          crc_d = crc16_byte(crc_q, data_q);
          if (idx_q == cnt_q) begin
            state_d = S_CRCL;
            data_d  = ~crc_d[7:0];
          end else begin
            data_d = mem_q[idx_q[IDX_W-1:0]];
            idx_d  = idx_q + CNT_W'(1);
          end
        end
      end
      S_CRCL: begin
        if (tx_fire) begin
          state_d = S_CRCH;
          data_d  = ~crc_q[15:8];
          last_d  = 1'b1;
        end
      end
      S_CRCH: begin
        if (tx_fire) begin
          state_d = S_WAITHS;
          valid_d = 1'b0;
          data_d  = 8'h00;
          last_d  = 1'b0;
        end
      end
      S_WAITHS: begin
        if (bus.i_ackRcvd) begin
          state_d  = S_IDLE;
          toggle_d = ~toggle_q;
          pend_d   = 1'b0;
          rdy_d    = 1'b1;
        end else if (bus.i_hsTimeout) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Toggle clear overrides any ACK toggle and drops a pending retry.
    if (bus.i_toggleClr) begin
      toggle_d = 1'b0;
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      toggle_q <= 1'b0;
      pend_q   <= 1'b0;
      hs_q     <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      crc_q    <= 16'hFFFF;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      last_q   <= 1'b0;
      acc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      toggle_q <= toggle_d;
      pend_q   <= pend_d;
      hs_q     <= hs_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      crc_q    <= crc_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      acc_q    <= acc_d;
      rdy_q    <= rdy_d;
    end
  end

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[bus.i_etWrIdx] <= bus.i_etWrByte;
    end
  end

  assign bus.o_etTxAccepted = acc_q;
  assign bus.o_etReady      = rdy_q;
  assign bus.o_txValid      = valid_q;
  assign bus.o_txData       = data_q;
  assign bus.o_txLast       = last_q;
endmodule

// File: tb/tb_usbfs_tx_pkt.sv
// Bench for usbfs_tx_pkt: directed and randomized IN transactions checked
// against a packet-level model of toggle, retry and CRC16.
module tb_usbfs_tx_pkt;
  localparam int unsigned MAX_PKT = 16;
  localparam int unsigned IDX_W   = $clog2(MAX_PKT);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  usbfs_tx_pkt_if #(.MAX_PKT(MAX_PKT)) bus ();

  usbfs_tx_pkt #(.MAX_PKT(MAX_PKT)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int           n_cmp  = 0;
  int           n_fail = 0;
  bit           exp_toggle = 1'b0;
  bit           exp_pend   = 1'b0;
  byte unsigned exp_buf[$];
  byte unsigned exp_q[$];
  byte unsigned txn_pl[$];
  byte unsigned got_b[$];
  bit           got_l[$];
  byte unsigned saved[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC16 as the MSB-first 0x8005 register fed LSB-first, reflected and inverted.
  function automatic logic [15:0] model_crc(input byte unsigned pl[$]);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    foreach (pl[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[15] ^ pl[i][k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int k = 0; k < 16; k++) r[k] = c[15-k];
    return ~r;
  endfunction

  function automatic void build_data();
    logic [15:0] crc;
    crc = model_crc(exp_buf);
    exp_q.delete();
    exp_q.push_back(exp_toggle ? 8'h4B : 8'hC3);
    foreach (exp_buf[i]) exp_q.push_back(exp_buf[i]);
    exp_q.push_back(crc[7:0]);
    exp_q.push_back(crc[15:8]);
  endfunction

  task automatic set_payload(input int len);
    txn_pl.delete();
    for (int i = 0; i < len; i++) txn_pl.push_back(8'($urandom));
  endtask

  // Accept bytes with random serializer back-pressure until the last byte.
  task automatic collect(input int budget);
    bit         started = 1'b0;
    bit         hold    = 1'b0;
    bit         done    = 1'b0;
    logic [7:0] pd      = 8'h00;
    logic       pl      = 1'b0;
    int         cyc     = 0;
    got_b.delete();
    got_l.delete();
    while (!done && cyc < budget) begin
      logic       v;
      logic       l;
      logic [7:0] d;
      bit         r;
      v = bus.o_txValid;
      d = bus.o_txData;
      l = bus.o_txLast;
      if (started) check("valid_gap", v, 1);
      if (hold) begin
        check("hold_data", d, pd);
        check("hold_last", l, pl);
      end
      if (v === 1'b1) started = 1'b1;
      r = ($urandom_range(0, 2) != 0);
      bus.i_txReady = r;
      if (v === 1'b1 && r) begin
        got_b.push_back(d);
        got_l.push_back(l);
        if (l === 1'b1) done = 1'b1;
      end
      hold = (v === 1'b1) && !r;
      pd = d;
      pl = l;
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_txReady = 1'b0;
    check("collect_done", done, 1);
  endtask

  task automatic compare_pkt(input string tag);
    check({tag, "_len"}, got_b.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
      check({tag, "_byte"}, got_b[i], exp_q[i]);
      check({tag, "_last"}, got_l[i], (i == exp_q.size() - 1));
    end
  endtask

  task automatic fill(input byte unsigned pl[$]);
    for (int i = 0; i < pl.size(); i++) begin
      bus.i_etWrEn   = 1'b1;
      bus.i_etWrIdx  = IDX_W'(i);
      bus.i_etWrByte = pl[i];
      @(posedge clk); #1;
    end
    if (pl.size() == MAX_PKT) begin
      // Full buffer exits FILL on its own; a further write must be ignored.
      bus.i_etWrIdx  = '0;
      bus.i_etWrByte = ~pl[0];
    end else begin
      bus.i_etWrEn = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // mode: 0 ack, 1 timeout, 2 ack+timeout, 3 ack+toggleClr, 4 timeout+toggleClr
  task automatic handshake(input int mode);
    bit ack;
    bit tmo;
    bit clr;
    ack = (mode == 0) || (mode == 2) || (mode == 3);
    tmo = (mode == 1) || (mode == 2) || (mode == 4);
    clr = (mode == 3) || (mode == 4);
    bus.i_ackRcvd   = ack;
    bus.i_hsTimeout = tmo;
    bus.i_toggleClr = clr;
    @(posedge clk); #1;
    bus.i_ackRcvd   = 1'b0;
    bus.i_hsTimeout = 1'b0;
    bus.i_toggleClr = 1'b0;
    check("et_ready", bus.o_etReady, ack);
    if (ack) begin
      exp_toggle = !exp_toggle;
      exp_pend   = 1'b0;
    end
    if (clr) begin
      exp_toggle = 1'b0;
      exp_pend   = 1'b0;
    end
    @(posedge clk); #1;
    check("et_ready_pulse", bus.o_etReady, 0);
  endtask

  // One IN token; the model decides between STALL, retry, new data and NAK.
  task automatic in_txn(input bit stall, input bit valid, input int hs_mode);
    int kind;
    if (stall) kind = 0;
    else if (exp_pend) kind = 1;
    else if (valid) kind = 2;
    else kind = 0;
    bus.i_etStall = stall;
    bus.i_etValid = valid;
    bus.i_inTok   = 1'b1;
    @(posedge clk); #1;
    bus.i_inTok   = 1'b0;
    bus.i_etStall = 1'b0;
    bus.i_etValid = 1'b0;
    check("tx_accepted", bus.o_etTxAccepted, (kind == 2));
    if (kind == 2) begin
      fill(txn_pl);
      exp_buf  = txn_pl;
      exp_pend = 1'b1;
    end
    check("first_valid", bus.o_txValid, 1);
    if (kind == 0) begin
      exp_q.delete();
      exp_q.push_back(stall ? 8'h1E : 8'h5A);
    end else begin
      build_data();
    end
    collect(400);
    bus.i_etWrEn = 1'b0;
    compare_pkt("pkt");
    check("valid_after", bus.o_txValid, 0);
    if (kind != 0) handshake(hs_mode);
  endtask

  initial begin
    bus.i_inTok     = 1'b0;
    bus.i_etValid   = 1'b0;
    bus.i_etStall   = 1'b0;
    bus.i_etWrEn    = 1'b0;
    bus.i_etWrIdx   = '0;
    bus.i_etWrByte  = 8'h00;
    bus.i_ackRcvd   = 1'b0;
    bus.i_hsTimeout = 1'b0;
    bus.i_toggleClr = 1'b0;
    bus.i_txReady   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_txValid", bus.o_txValid, 0);
    check("rst_txData", bus.o_txData, 0);
    check("rst_txLast", bus.o_txLast, 0);
    check("rst_accepted", bus.o_etTxAccepted, 0);
    check("rst_etReady", bus.o_etReady, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // NAK, then STALL taking priority over valid data
    set_payload(0);
    in_txn(1'b0, 1'b0, 0);
    in_txn(1'b1, 1'b1, 0);

    // Zero-length packet: C3 00 00, then DATA1 for the next one
    in_txn(1'b0, 1'b1, 0);
    check("zlp_pid", got_b[0], 8'hC3);
    check("zlp_crcl", got_b[1], 8'h00);
    check("zlp_crch", got_b[2], 8'h00);
    set_payload(2);
    in_txn(1'b0, 1'b1, 0);
    check("data1_pid", got_b[0], 8'h4B);

    // Known CRC vector "123456789"
    txn_pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    in_txn(1'b0, 1'b1, 0);
    check("crc_pid", got_b[0], 8'hC3);
    check("crc_lo", got_b[10], 8'hC8);
    check("crc_hi", got_b[11], 8'hB4);

    // Timeout then retry of identical bytes; ACK with toggle clear -> DATA0
    set_payload(4);
    in_txn(1'b0, 1'b1, 1);
    saved = got_b;
    set_payload(3);
    in_txn(1'b0, 1'($urandom), 3);
    check("retry_len", got_b.size(), saved.size());
    for (int i = 0; i < saved.size(); i++) check("retry_byte", got_b[i], saved[i]);
    set_payload(1);
    in_txn(1'b0, 1'b1, 0);
    check("clr_pid", got_b[0], 8'hC3);

    // ACK beats a coincident timeout; toggle clear with timeout drops the retry
    set_payload(5);
    in_txn(1'b0, 1'b1, 2);
    set_payload(6);
    in_txn(1'b0, 1'b1, 4);
    set_payload(2);
    in_txn(1'b0, 1'b1, 0);

    // Full buffer
    set_payload(MAX_PKT);
    in_txn(1'b0, 1'b1, 0);
    check("full_len", got_b.size(), MAX_PKT + 3);

    for (int t = 0; t < 14; t++) begin
      set_payload(int'($urandom_range(0, MAX_PKT)));
      in_txn(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
             int'($urandom_range(0, 4)));
    end

    // Reset in the middle of DATA while on DATA1
    if (exp_pend) begin
      set_payload(0);
      in_txn(1'b0, 1'b1, 0);
    end
    if (!exp_toggle) begin
      set_payload(0);
      in_txn(1'b0, 1'b1, 0);
    end
    set_payload(8);
    bus.i_etValid = 1'b1;
    bus.i_inTok   = 1'b1;
    @(posedge clk); #1;
    bus.i_inTok   = 1'b0;
    bus.i_etValid = 1'b0;
    fill(txn_pl);
    bus.i_txReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_valid", bus.o_txValid, 1);
    check("mid_data", bus.o_txData, txn_pl[2]);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.o_txValid, 0);
    check("arst_last", bus.o_txLast, 0);
    check("arst_data", bus.o_txData, 0);
    bus.i_txReady = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    exp_toggle = 1'b0;
    exp_pend   = 1'b0;
    @(posedge clk); #1;
    set_payload(3);
    in_txn(1'b0, 1'b1, 0);
    check("post_rst_pid", got_b[0], 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
